// File: rtl/cv32e40p_pkg.sv
// Shared types for the cv32e40p wake/power sequencing slice.
// Power gating states are only reachable with CV32E40P_PWR_GATE_EN.
package cv32e40p_pkg;

  localparam int unsigned WAKE_CNT_W = 16;

  typedef enum logic [2:0] {
    WAKE_OFF    = 3'd0,
    WAKE_BOOT   = 3'd1,
    WAKE_RUN    = 3'd2,
    WAKE_SLEEP  = 3'd3,
    WAKE_PD_REQ = 3'd4,
    WAKE_PD     = 3'd5,
    WAKE_PU_REQ = 3'd6
  } wake_state_e;

  function automatic logic is_pwr_gated(
    input wake_state_e s
  );
    return (s == WAKE_PD_REQ) ||
           (s == WAKE_PD) ||
           (s == WAKE_PU_REQ);
  endfunction

endpackage

// File: rtl/cv32e40p_wake_cnt.sv
// 16-bit cycle counter: clear, load, decrement to zero,
// increment saturating at sat_val_i.
module cv32e40p_wake_cnt
  import cv32e40p_pkg::*;
#(
  parameter int unsigned W = WAKE_CNT_W
) (
  input  logic         clk_ungated_i,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  input  logic         inc_i,
  input  logic [W-1:0] sat_val_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o,
  output logic         sat_o
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE;
    end else if (inc_i && (cnt_q < sat_val_i)) begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk_ungated_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);
  assign sat_o  = (cnt_q == sat_val_i);

endmodule

// File: rtl/cv32e40p_wake_unit.sv
// Core boot, sleep and wake sequencer on the ungated clock.
// Define CV32E40P_PWR_GATE_EN to enable the power-down handshake.
module cv32e40p_wake_unit #(
  parameter int unsigned BOOT_DELAY     = 16,
  parameter int unsigned IDLE_THRESHOLD = 64
) (
  input  logic        clk_ungated_i,
  input  logic        rst_n,
  input  logic        soc_fetch_en_i,
  input  logic        core_sleep_i,
  input  logic [31:0] irq_i,
  input  logic [31:0] irq_mask_i,
  input  logic        debug_req_i,
  input  logic        pwr_ack_i,
  output logic        fetch_enable_o,
  output logic [31:0] irq_o,
  output logic        debug_req_o,
  output logic        pwr_req_o,
  output logic        iso_en_o,
  output logic [2:0]  state_o
);

  import cv32e40p_pkg::*;

  localparam logic [WAKE_CNT_W-1:0] BOOT_VAL =
    16'(BOOT_DELAY);

  wake_state_e state_q;
  wake_state_e state_d;

  logic wake;
  logic pend_q;
  logic pend_d;
  logic fetch_en_q;
  logic fetch_en_d;
  logic pwr_req_q;
  logic pwr_req_d;
  logic iso_en_q;
  logic iso_en_d;
  logic gated;

  logic                  boot_load;
  logic                  boot_dec;
  logic                  boot_zero;
  logic [WAKE_CNT_W-1:0] boot_cnt;
  logic                  unused_boot_sat;

  assign wake = (|(irq_i & irq_mask_i)) || debug_req_i;

  assign boot_load = (state_q == WAKE_OFF) && soc_fetch_en_i;
  assign boot_dec  = (state_q == WAKE_BOOT);

  cv32e40p_wake_cnt #(
    .W (WAKE_CNT_W)
  ) u_boot_cnt (
    .clk_ungated_i (clk_ungated_i),
    .rst_n         (rst_n),
    .clr_i         (1'b0),
    .load_i        (boot_load),
    .load_val_i    (BOOT_VAL),
    .dec_i         (boot_dec),
    .inc_i         (1'b0),
    .sat_val_i     ({WAKE_CNT_W{1'b1}}),
    .cnt_o         (boot_cnt),
    .zero_o        (boot_zero),
    .sat_o         (unused_boot_sat)
  );

`ifdef CV32E40P_PWR_GATE_EN
  localparam logic [WAKE_CNT_W-1:0] IDLE_VAL =
    16'(IDLE_THRESHOLD);

  logic                  idle_clr;
  logic                  idle_inc;
  logic                  idle_sat;
  logic                  unused_idle_zero;
  logic [WAKE_CNT_W-1:0] unused_idle_cnt;

  assign idle_clr = (state_q == WAKE_RUN) &&
                    (state_d == WAKE_SLEEP);
  assign idle_inc = (state_q == WAKE_SLEEP) &&
                    (state_d == WAKE_SLEEP);

  cv32e40p_wake_cnt #(
    .W (WAKE_CNT_W)
  ) u_idle_cnt (
    .clk_ungated_i (clk_ungated_i),
    .rst_n         (rst_n),
    .clr_i         (idle_clr),
    .load_i        (1'b0),
    .load_val_i    ('0),
    .dec_i         (1'b0),
    .inc_i         (idle_inc),
    .sat_val_i     (IDLE_VAL),
    .cnt_o         (unused_idle_cnt),
    .zero_o        (unused_idle_zero),
    .sat_o         (idle_sat)
  );
`else
  logic unused_pwr_ack;
  assign unused_pwr_ack = pwr_ack_i;
`endif

  logic [WAKE_CNT_W-1:0] unused_boot_cnt;
  assign unused_boot_cnt = boot_cnt;

  always_ff @(posedge clk_ungated_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WAKE_OFF;
      pend_q     <= 1'b0;
      fetch_en_q <= 1'b0;
      pwr_req_q  <= 1'b0;
      iso_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      fetch_en_q <= fetch_en_d;
      pwr_req_q  <= pwr_req_d;
      iso_en_q   <= iso_en_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAKE_OFF: begin
        if (soc_fetch_en_i) state_d = WAKE_BOOT;
      end
      WAKE_BOOT: begin
        if (boot_zero) state_d = WAKE_RUN;
      end
      WAKE_RUN: begin
        if (core_sleep_i && !wake) state_d = WAKE_SLEEP;
      end
      WAKE_SLEEP: begin
        if (!core_sleep_i || wake) begin
          state_d = WAKE_RUN;
`ifdef CV32E40P_PWR_GATE_EN
        end else if (idle_sat) begin
          state_d = WAKE_PD_REQ;
`endif
        end
      end
      // Once requested, power-down completes before any wake.
      WAKE_PD_REQ: begin
        if (pwr_ack_i) state_d = WAKE_PD;
      end
      WAKE_PD: begin
        if (wake || pend_q) state_d = WAKE_PU_REQ;
      end
      WAKE_PU_REQ: begin
        if (!pwr_ack_i) state_d = WAKE_RUN;
      end
      default: state_d = WAKE_OFF;
    endcase

    pend_d = pend_q;
    if ((state_d == WAKE_RUN) && (state_q != WAKE_RUN)) begin
      pend_d = 1'b0;
    end else if (is_pwr_gated(state_q) && wake) begin
      pend_d = 1'b1;
    end
  end

  always_comb begin
    fetch_en_d = fetch_en_q || (state_d == WAKE_RUN);
    pwr_req_d  = 1'b0;
    iso_en_d   = 1'b0;
`ifdef CV32E40P_PWR_GATE_EN
    pwr_req_d  = (state_d == WAKE_PD_REQ) ||
                 (state_d == WAKE_PD);
    iso_en_d   = is_pwr_gated(state_d);
`endif
    gated       = is_pwr_gated(state_q);
    irq_o       = gated ? 32'h0 : irq_i;
    debug_req_o = !gated && debug_req_i;
  end

  assign fetch_enable_o = fetch_en_q;
  assign pwr_req_o      = pwr_req_q;
  assign iso_en_o       = iso_en_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_cv32e40p_wake_unit.sv
// Scoreboard bench for cv32e40p_wake_unit (BOOT_DELAY=16,
// IDLE_THRESHOLD=4); power tests need CV32E40P_PWR_GATE_EN.
module tb_cv32e40p_wake_unit;

  import cv32e40p_pkg::*;

  typedef struct packed {
    logic [2:0] st;
    logic       fe;
    logic       pr;
    logic       iso;
  } exp_t;

  logic        clk_ungated_i;
  logic        rst_n;
  logic        soc_fetch_en_i;
  logic        core_sleep_i;
  logic [31:0] irq_i;
  logic [31:0] irq_mask_i;
  logic        debug_req_i;
  logic        pwr_ack_i;
  logic        fetch_enable_o;
  logic [31:0] irq_o;
  logic        debug_req_o;
  logic        pwr_req_o;
  logic        iso_en_o;
  logic [2:0]  state_o;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t e;
  exp_t got;

  localparam logic [2:0] S_OFF  = 3'(WAKE_OFF);
  localparam logic [2:0] S_BOOT = 3'(WAKE_BOOT);
  localparam logic [2:0] S_RUN  = 3'(WAKE_RUN);
  localparam logic [2:0] S_SLP  = 3'(WAKE_SLEEP);
  localparam logic [2:0] S_PDR  = 3'(WAKE_PD_REQ);
  localparam logic [2:0] S_PD   = 3'(WAKE_PD);
  localparam logic [2:0] S_PUR  = 3'(WAKE_PU_REQ);

  cv32e40p_wake_unit #(
    .BOOT_DELAY     (16),
    .IDLE_THRESHOLD (4)
  ) dut (
    .clk_ungated_i  (clk_ungated_i),
    .rst_n          (rst_n),
    .soc_fetch_en_i (soc_fetch_en_i),
    .core_sleep_i   (core_sleep_i),
    .irq_i          (irq_i),
    .irq_mask_i     (irq_mask_i),
    .debug_req_i    (debug_req_i),
    .pwr_ack_i      (pwr_ack_i),
    .fetch_enable_o (fetch_enable_o),
    .irq_o          (irq_o),
    .debug_req_o    (debug_req_o),
    .pwr_req_o      (pwr_req_o),
    .iso_en_o       (iso_en_o),
    .state_o        (state_o)
  );

  initial clk_ungated_i = 1'b0;
  always #5 clk_ungated_i = ~clk_ungated_i;

  task automatic tick();
    @(posedge clk_ungated_i);
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    soc_fetch_en_i = 1'b0;
    core_sleep_i   = 1'b0;
    irq_i          = '0;
    irq_mask_i     = '0;
    debug_req_i    = 1'b0;
    pwr_ack_i      = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic do_boot();
    soc_fetch_en_i = 1'b1;
    tick();
    soc_fetch_en_i = 1'b0;
    repeat (17) tick();
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    irq_i = 32'hA5A5_0001;
    debug_req_i = 1'b1;
    #1;
    got = {state_o, fetch_enable_o, pwr_req_o, iso_en_o};
    checks++;
    if (got !== {S_OFF, 3'b000}) begin
      errors++;
      $display("FAIL reset_state got %h exp %h",
               got, {S_OFF, 3'b000});
    end
    checks++;
    if (irq_o !== 32'hA5A5_0001 || debug_req_o !== 1'b1) begin
      errors++;
      $display("FAIL off_passthru got %h/%b exp a5a50001/1",
               irq_o, debug_req_o);
    end
    rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (state_o !== S_OFF || fetch_enable_o !== 1'b0) begin
      errors++;
      $display("FAIL off_idle got st %0d fe %b exp 0/0",
               state_o, fetch_enable_o);
    end
    irq_i = '0;
    debug_req_i = 1'b0;
  endtask

  task automatic test_boot();
    do_reset();
    sb.delete();
    for (int k = 0; k < 20; k++) begin
      e.st  = (k < 17) ? S_BOOT : S_RUN;
      e.fe  = (k >= 17);
      e.pr  = 1'b0;
      e.iso = 1'b0;
      sb.push_back(e);
    end
    soc_fetch_en_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k == 0) soc_fetch_en_i = 1'b0;
      e = sb.pop_front();
      got = {state_o, fetch_enable_o, pwr_req_o, iso_en_o};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL boot cyc %0d got %h exp %h", k, got, e);
      end
    end
  endtask

  task automatic test_run_passthru();
    logic [31:0] pi [4];
    logic [31:0] pm [4];
    logic        pd [4];
    pi[0] = 32'h0000_0001; pm[0] = 32'h0; pd[0] = 1'b0;
    pi[1] = 32'h8000_0000; pm[1] = 32'hFFFF_FFFF; pd[1] = 1'b1;
    pi[2] = 32'h1234_5678; pm[2] = 32'h0F0F_0F0F; pd[2] = 1'b0;
    pi[3] = 32'h0;         pm[3] = 32'hFFFF_FFFF; pd[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      irq_i = pi[i];
      irq_mask_i = pm[i];
      debug_req_i = pd[i];
      #1;
      checks++;
      if (irq_o !== pi[i] || debug_req_o !== pd[i]) begin
        errors++;
        $display("FAIL run_passthru %0d got %h/%b exp %h/%b",
                 i, irq_o, debug_req_o, pi[i], pd[i]);
      end
      tick();
      checks++;
      if (state_o !== S_RUN || fetch_enable_o !== 1'b1) begin
        errors++;
        $display("FAIL run_hold %0d got st %0d fe %b exp 2/1",
                 i, state_o, fetch_enable_o);
      end
    end
    irq_i = '0;
    irq_mask_i = '0;
    debug_req_i = 1'b0;
  endtask

  task automatic test_sleep_mask();
    sb.delete();
    for (int k = 0; k < 4; k++) sb.push_back({S_SLP, 3'b100});
    sb.push_back({S_RUN, 3'b100});
    irq_i = 32'h1;
    irq_mask_i = 32'h0;
    core_sleep_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      e = sb.pop_front();
      got = {state_o, fetch_enable_o, pwr_req_o, iso_en_o};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL sleep_mask cyc %0d got %h exp %h",
                 k, got, e);
      end
    end
    checks++;
    if (irq_o !== 32'h1) begin
      errors++;
      $display("FAIL sleep_passthru got %h exp 1", irq_o);
    end
    debug_req_i = 1'b1;
    tick();
    e = sb.pop_front();
    got = {state_o, fetch_enable_o, pwr_req_o, iso_en_o};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL sleep_dbg_wake got %h exp %h", got, e);
    end
    debug_req_i = 1'b0;
    core_sleep_i = 1'b0;
    irq_i = '0;
    tick();
  endtask

  task automatic test_sleep_irq_wake();
    core_sleep_i = 1'b1;
    tick();
    checks++;
    if (state_o !== S_SLP) begin
      errors++;
      $display("FAIL irq_sleep got %0d exp %0d", state_o, S_SLP);
    end
    irq_i = 32'h0000_0100;
    irq_mask_i = 32'h0000_0100;
    tick();
    checks++;
    if (state_o !== S_RUN) begin
      errors++;
      $display("FAIL irq_wake got %0d exp %0d", state_o, S_RUN);
    end
    tick();
    checks++;
    if (state_o !== S_RUN) begin
      errors++;
      $display("FAIL wake_blocks_sleep got %0d exp %0d",
               state_o, S_RUN);
    end
    irq_i = '0;
    irq_mask_i = '0;
    core_sleep_i = 1'b0;
    tick();
  endtask

`ifndef CV32E40P_PWR_GATE_EN
  task automatic test_no_pwr_gate();
    core_sleep_i = 1'b1;
    pwr_ack_i = 1'b1;
    tick();
    for (int k = 0; k < 1000; k++) begin
      tick();
      checks++;
      if (state_o !== S_SLP || pwr_req_o !== 1'b0 ||
          iso_en_o !== 1'b0) begin
        errors++;
        $display("FAIL no_pg cyc %0d got st %0d pr %b iso %b",
                 k, state_o, pwr_req_o, iso_en_o);
      end
    end
    core_sleep_i = 1'b0;
    pwr_ack_i = 1'b0;
    tick();
    checks++;
    if (state_o !== S_RUN) begin
      errors++;
      $display("FAIL no_pg_exit got %0d exp %0d", state_o, S_RUN);
    end
  endtask
`else
  task automatic test_pd_entry();
    sb.delete();
    for (int k = 0; k < 5; k++) sb.push_back({S_SLP, 3'b100});
    sb.push_back({S_PDR, 3'b111});
    core_sleep_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      e = sb.pop_front();
      got = {state_o, fetch_enable_o, pwr_req_o, iso_en_o};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL pd_entry cyc %0d got %h exp %h",
                 k, got, e);
      end
    end
  endtask

  task automatic test_pd_wake();
    irq_i = 32'h8;
    irq_mask_i = 32'h8;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (state_o !== S_PDR || irq_o !== 32'h0 ||
          pwr_req_o !== 1'b1) begin
        errors++;
        $display("FAIL pd_req_hold %0d got st %0d irq %h pr %b",
                 k, state_o, irq_o, pwr_req_o);
      end
    end
    sb.delete();
    sb.push_back({S_PD, 3'b111});
    sb.push_back({S_PUR, 3'b101});
    sb.push_back({S_RUN, 3'b100});
    pwr_ack_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (k == 1) begin
        checks++;
        if (irq_o !== 32'h0 || debug_req_o !== 1'b0) begin
          errors++;
          $display("FAIL pu_irq_gate got %h exp 0", irq_o);
        end
        core_sleep_i = 1'b0;
        pwr_ack_i = 1'b0;
      end
      e = sb.pop_front();
      got = {state_o, fetch_enable_o, pwr_req_o, iso_en_o};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL pd_wake cyc %0d got %h exp %h",
                 k, got, e);
      end
    end
    checks++;
    if (irq_o !== 32'h8) begin
      errors++;
      $display("FAIL run_irq_fwd got %h exp 8", irq_o);
    end
    irq_i = '0;
    irq_mask_i = '0;
    tick();
  endtask

  task automatic test_reset_pd();
    do_reset();
    do_boot();
    core_sleep_i = 1'b1;
    repeat (6) tick();
    pwr_ack_i = 1'b1;
    tick();
    tick();
    checks++;
    if (state_o !== S_PD || pwr_req_o !== 1'b1) begin
      errors++;
      $display("FAIL pd_reach got st %0d pr %b exp 5/1",
               state_o, pwr_req_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    got = {state_o, fetch_enable_o, pwr_req_o, iso_en_o};
    checks++;
    if (got !== {S_OFF, 3'b000}) begin
      errors++;
      $display("FAIL reset_in_pd got %h exp %h",
               got, {S_OFF, 3'b000});
    end
    do_reset();
  endtask
`endif

  task automatic test_async_reset();
    do_reset();
    do_boot();
    checks++;
    if (state_o !== S_RUN || fetch_enable_o !== 1'b1) begin
      errors++;
      $display("FAIL rerun got st %0d fe %b exp 2/1",
               state_o, fetch_enable_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (state_o !== S_OFF || fetch_enable_o !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got st %0d fe %b exp 0/0",
               state_o, fetch_enable_o);
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_boot();
    test_run_passthru();
    test_sleep_mask();
    test_sleep_irq_wake();
`ifndef CV32E40P_PWR_GATE_EN
    test_no_pwr_gate();
`else
    test_pd_entry();
    test_pd_wake();
    test_reset_pd();
`endif
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cv32e40p_wake_unit.md
CV32E40P_WAKE_UNIT -- requirements
Module: cv32e40p_wake_unit

Interface
REQ-001 SHALL have parameter BOOT_DELAY, 16, cycles from soc fetch enable to core fetch_enable_o, legal range 0..65535.
REQ-002 SHALL have parameter IDLE_THRESHOLD, 64, sleep cycles before power-down request, legal range 1..65535.
REQ-003 SHALL have port clk_ungated_i input 1: free-running clock; all state is clocked on its rising edge.
REQ-004 SHALL have port rst_n input 1: asynchronous, active-low reset.
REQ-005 SHALL have port soc_fetch_en_i input 1: SoC boot request, level.
REQ-006 SHALL have port core_sleep_i input 1: core is asleep with its clock gated.
REQ-007 SHALL have port irq_i input 32: SoC interrupt lines, level.
REQ-008 SHALL have port irq_mask_i input 32: wake-enable mask per line.
REQ-009 SHALL have port debug_req_i input 1: external debug request, level.
REQ-010 SHALL have port pwr_ack_i input 1: power switch acknowledge (4-phase).
REQ-011 SHALL have port fetch_enable_o output 1: core fetch enable.
REQ-012 SHALL have port irq_o output 32: interrupts forwarded to core.
REQ-013 SHALL have port debug_req_o output 1: debug request forwarded to core.
REQ-014 SHALL have port pwr_req_o output 1: core power-down request.
REQ-015 SHALL have port iso_en_o output 1: core output isolation enable.
REQ-016 SHALL have port state_o output 3: current FSM state, for status.

Function
REQ-017 SHALL implement FSM states OFF, BOOT, RUN, SLEEP, PD_REQ, PD, PU_REQ.
REQ-018 wake SHALL be defined as (|(irq_i & irq_mask_i)) || debug_req_i.
REQ-019 OFF: soc_fetch_en_i=1 -> BOOT with boot counter loaded to BOOT_DELAY.
REQ-020 BOOT: counter decrements each cycle; at 0 -> RUN, so BOOT_DELAY=0 enters RUN one cycle after BOOT.
REQ-021 fetch_enable_o SHALL be registered, rise on the cycle state becomes RUN, and stay 1 until reset; soc_fetch_en_i deassertion after BOOT is ignored.
REQ-022 RUN: core_sleep_i=1 && !wake -> SLEEP with idle counter cleared to 0.
REQ-023 SLEEP: core_sleep_i=0 or wake -> RUN; otherwise idle counter increments, saturating at IDLE_THRESHOLD.
REQ-024 SLEEP: idle counter == IDLE_THRESHOLD && core_sleep_i && !wake -> PD_REQ.
REQ-025 PD_REQ: pwr_req_o=1 and iso_en_o=1; pwr_ack_i=1 -> PD; wake here SHALL NOT abort the handshake.
REQ-026 PD: pwr_req_o=1; wake or wake_pending_q -> PU_REQ.
REQ-027 PU_REQ: pwr_req_o=0; pwr_ack_i=0 -> RUN; iso_en_o SHALL drop on the cycle state becomes RUN.
REQ-028 wake_pending_q SHALL set on wake in PD_REQ/PD/PU_REQ and clear on entry to RUN.
REQ-029 irq_o = irq_i and debug_req_o = debug_req_i combinationally in OFF/BOOT/RUN/SLEEP; both SHALL be 0 in PD_REQ/PD/PU_REQ.
REQ-030 All outputs except irq_o/debug_req_o SHALL be registered.

Reset
REQ-031 Reset SHALL force state OFF, both counters 0, wake_pending_q 0, and fetch_enable_o, pwr_req_o, iso_en_o 0, immediately and asynchronously.
REQ-032 Reset mid-handshake SHALL drop pwr_req_o regardless of pwr_ack_i.

Configuration
REQ-033 Macro CV32E40P_PWR_GATE_EN defined: PD_REQ/PD/PU_REQ behaviour per REQ-024..028.
REQ-034 Macro undefined: SLEEP never exits to PD_REQ, the idle counter is removed, pwr_req_o and iso_en_o are tied 0, and pwr_ack_i is unused.

Structure
REQ-035 Typedef wake_state_e (3-bit enum) SHALL live in cv32e40p_pkg.
REQ-036 Boot and idle counters SHALL each be instances of sub-module cv32e40p_wake_cnt (16-bit load/decrement/increment-saturate counter).

Verification
REQ-037 BOOT_DELAY=16, soc_fetch_en_i pulsed 1 cycle -> fetch_enable_o rises exactly 17 cycles after the pulse edge and stays 1.
REQ-038 IDLE_THRESHOLD=4, core_sleep_i held 1 in RUN, no irq -> pwr_req_o=1 and iso_en_o=1 on the 6th cycle after core_sleep_i rises.
REQ-039 In PD_REQ, irq_i[3]=1 with mask bit 3 set, pwr_ack_i delayed 5 cycles -> PD then immediately PU_REQ, irq_o=0 throughout, and irq_o[3]=1 once RUN is re-entered.
REQ-040 irq_i=0x1 with irq_mask_i=0x0 in SLEEP -> stays SLEEP; debug_req_i=1 -> RUN next cycle.
REQ-041 rst_n asserted while in PD with pwr_ack_i=1 -> pwr_req_o, iso_en_o and fetch_enable_o are 0 immediately and state_o=OFF.
REQ-042 Built without CV32E40P_PWR_GATE_EN, sleep 1000 cycles -> pwr_req_o stays 0 and state_o remains SLEEP.
